seq_mult16: RTL and testbench
=============================

// Module: seq_mult16
// PURPOSE
//  Sequential 16x16 unsigned shift-add multiplier. It is the datapath stage built around the
//  team's 16-bit carry-lookahead adder and consumes that adder's sum/carry every cycle.
//  Start/Busy/Done handshake toward the controlling FSM; 32-bit product held until next Start.
// PARAMETERS
//  WIDTH   16   operand width; product is 2*WIDTH; iteration count = WIDTH (only 16 verified)
// PORTS
//  clk     in   1    single clock, all state updates on rising edge
//  rst_n   in   1    synchronous reset, active-low, sampled on rising clk
//  Start   in   1    request; sampled only in IDLE or DONE state
//  A       in   16   multiplicand, captured on accepted Start
//  B       in   16   multiplier, captured on accepted Start
//  P       out  32   product register
//  Busy    out  1    high while state == RUN
//  Done    out  1    one-cycle pulse when P becomes valid
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state=IDLE, P=0, Busy=0, Done=0, internal regs=0; overrides all.
//  - Internal regs: MC[31:0] multiplicand (zero-extended), MQ[15:0] multiplier, CNT[4:0], ACC=P.
//  - States: IDLE -> RUN on Start; RUN -> DONE after last iteration; DONE -> IDLE next cycle,
//    or DONE -> RUN if Start=1 in DONE (back-to-back operation allowed).
//  - Accept (edge 0): MC<={16'b0,A}, MQ<=B, P<=0, CNT<=0, state<=RUN. Busy=1 from edge 0.
//  - RUN iteration (edges 1..16): if MQ[0] P<=P+MC (32-bit add built from two chained
//    16-bit lookahead slices, carry out of bit 31 discarded; never set for unsigned 16x16);
//    MC<=MC<<1; MQ<=MQ>>1; CNT<=CNT+1. At CNT==15 the iteration moves state to DONE.
//  - DONE (after edge 16): Done=1, Busy=0 for exactly one cycle; P final and stable.
//  - Latency: Start sampled at edge 0 -> Done high after edge 16 (16 clk), P valid same cycle.
//  - P holds its value in IDLE indefinitely; it is cleared only on reset or next accepted Start.
//  - Start while Busy=1: ignored, no effect on operands or count.
//  - A/B changes after accept: ignored (operands registered).
//  - Reset mid-RUN: abort, all outputs to reset values next cycle, no Done pulse.
//  - Zero operands: still full 16 iterations (unless EARLY_TERM_EN); P=0.
// CONFIGURATION
//  EARLY_TERM_EN defined: in RUN, if MQ==0 at an edge, no add, state<=DONE immediately.
//   Latency = 1 + index of highest set bit of B, +1; B=0 -> Done after edge 1.
//   Result identical to full run. Done/Busy protocol unchanged.
//  EARLY_TERM_EN undefined: fixed 16-iteration latency, MQ==0 has no effect.
// TESTING
//  1. reset, A=0x0003 B=0x0005 Start 1 clk -> Done after 16 clk, P=0x0000000F, Busy=0.
//  2. A=0xFFFF B=0xFFFF -> P=0xFFFE0001; Done exactly one cycle wide.
//  3. A=0x1234 B=0x0002, pulse Start again at clk 5 with A=B=0 -> ignored, P=0x00002468.
//  4. Start A=0x00FF B=0x0100, rst_n=0 at clk 8 -> P=0 Busy=0, no Done; new op runs normally.
//  5. Start held high continuously, A=0x0002 B=0x0003 -> Done every 17 clk, P=0x00000006 each.
//  6. EARLY_TERM_EN: A=0x1234 B=0x0001 -> Done after edge 2, P=0x00001234; undefined -> edge 16.

Source files
------------

// File: rtl/seq_mult16.sv
// seq_mult16: sequential shift-add unsigned multiplier with Start/Busy/Done handshake
// Ports: clk, rst_n (sync, active-low), Start, A/B operands in, P product out,
//        Busy high while running, Done one-cycle pulse when P is valid.
// Optional: define EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module seq_mult16 #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] P,
  output logic               Busy,
  output logic               Done
);
  localparam int PW = 2 * WIDTH;
  localparam int NS = PW / 16;
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [PW-1:0] mc;
  logic [WIDTH-1:0] mq;
  logic [CW-1:0] cnt;
  logic [PW-1:0] sum;
  // 16-bit adder with 4-bit lookahead groups; returns {carry_out, sum}
  function automatic logic [16:0] cla16(input logic [15:0] a, input logic [15:0] b, input logic ci);
    logic [15:0] g, p;
    logic [16:0] c;
    logic [3:0] gg, gp;
    logic [4:0] gc;
    g = a & b;
    p = a ^ b;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | p[4*k+3] & (g[4*k+2] | p[4*k+2] & (g[4*k+1] | p[4*k+1] & g[4*k]));
      gp[k] = &p[4*k+:4];
    end
    gc[0] = ci;
    for (int k = 0; k < 4; k++) gc[k+1] = gg[k] | gp[k] & gc[k];
    for (int k = 0; k < 4; k++) begin
      c[4*k] = gc[k];
      for (int j = 1; j < 4; j++) c[4*k+j] = g[4*k+j-1] | p[4*k+j-1] & c[4*k+j-1];
    end
    c[16] = gc[4];
    return {c[16], p ^ c[15:0]};
  endfunction
  // Chains the 16-bit slices; the final carry is dropped since a 16x16 product never overflows
  function automatic logic [PW-1:0] addw(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW-1:0] s;
    logic [16:0] r;
    logic cy;
    s = '0;
    cy = 1'b0;
    for (int k = 0; k < NS; k++) begin
      r = cla16(a[16*k+:16], b[16*k+:16], cy);
      s[16*k+:16] = r[15:0];
      cy = r[16];
    end
    return s;
  endfunction
  always_comb sum = addw(P, mc);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      P <= '0;
      mc <= '0;
      mq <= '0;
      cnt <= '0;
      Busy <= 1'b0;
      Done <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (state != RUN) begin
        if (Start) begin
          mc <= {{WIDTH{1'b0}}, A};
          mq <= B;
          P <= '0;
          cnt <= '0;
          state <= RUN;
          Busy <= 1'b1;
        end else begin
          state <= IDLE;
        end
      end
`ifdef EARLY_TERM_EN
      else if (mq == '0) begin
        state <= DONE;
        Busy <= 1'b0;
        Done <= 1'b1;
      end
`endif
      else begin
        if (mq[0]) P <= sum;
        mc <= mc << 1;
        mq <= mq >> 1;
        cnt <= cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          state <= DONE;
          Busy <= 1'b0;
          Done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_mult16.sv
// tb_seq_mult16: randomized self-checking bench for seq_mult16 against an arithmetic reference
module tb_seq_mult16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic Start = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic [31:0] P;
  logic Busy, Done;
  int total = 0;
  int bad = 0;
  seq_mult16 dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .A(A), .B(B), .P(P), .Busy(Busy), .Done(Done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic int exp_lat(input logic [15:0] b);
`ifdef EARLY_TERM_EN
    int hb = -1;
    for (int i = 0; i < 16; i++) if (b[i]) hb = i;
    return (hb + 2 > 16) ? 16 : hb + 2;
`else
    return 16;
`endif
  endfunction
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b, input int pulse_at);
    int n;
    logic [31:0] e;
    e = {16'b0, a} * {16'b0, b};
    @(negedge clk);
    A = a;
    B = b;
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    A = 16'($urandom);
    B = 16'($urandom);
    chk({tag, "_busy_run"}, 32'(Busy), 32'd1);
    n = 0;
    while (!Done && n < 60) begin
      @(negedge clk);
      n++;
      if (n == pulse_at) begin
        Start = 1'b1;
        A = '0;
        B = '0;
      end else begin
        Start = 1'b0;
      end
    end
    Start = 1'b0;
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat(b)));
    chk({tag, "_done"}, 32'(Done), 32'd1);
    chk({tag, "_p"}, P, e);
    chk({tag, "_busy_done"}, 32'(Busy), 32'd0);
    @(negedge clk);
    chk({tag, "_done_width"}, 32'(Done), 32'd0);
    chk({tag, "_p_hold"}, P, e);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    int n, pa, seen;
    logic [15:0] ra, rb;
    repeat (3) @(negedge clk);
    chk("rst_p", P, 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    rst_n = 1'b1;
    run_op("t1", 16'h0003, 16'h0005, 0);
    run_op("t2", 16'hFFFF, 16'hFFFF, 0);
    pa = exp_lat(16'h0002) > 5 ? 5 : exp_lat(16'h0002) - 1;
    run_op("t3", 16'h1234, 16'h0002, pa);
    repeat (5) @(negedge clk);
    chk("idle_hold", P, 32'h00002468);
    @(negedge clk);
    A = 16'h00FF;
    B = 16'h0100;
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_p", P, 32'd0);
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_done", 32'(Done), 32'd0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (Done) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    run_op("t4_after", 16'h00FF, 16'h0100, 0);
    @(negedge clk);
    A = 16'h0002;
    B = 16'h0003;
    Start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!Done && n < 60);
    chk("held_first", 32'(n), 32'(exp_lat(16'h0003) + 1));
    chk("held_p0", P, 32'h6);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!Done && n < 60);
      chk("held_period", 32'(n), 32'(exp_lat(16'h0003) + 1));
      chk("held_p", P, 32'h6);
    end
    Start = 1'b0;
    @(negedge clk);
    run_op("zero", 16'h0000, 16'h0000, 0);
    run_op("b_zero", 16'hBEEF, 16'h0000, 0);
    run_op("t6", 16'h1234, 16'h0001, 0);
    run_op("msb", 16'h8001, 16'h8000, 0);
    for (int i = 0; i < 25; i++) begin
      ra = 16'($urandom);
      rb = (i % 4 == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      run_op("rand", ra, rb, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
